// File: rtl/mb_wbuf.sv
// MBOX line buffer: wrap-around memory fill with odd-parity checking, EBOX store port,
// registered read port with regenerated parity, and a channel FIFO with optional halfword swap.
module mb_wbuf #(
    parameter int WIDTH   = 36,
    parameter int NWORDS  = 4,
    parameter int CHDEPTH = 128,
    localparam int AW = $clog2(NWORDS),
    localparam int CW = $clog2(CHDEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fillStart,
    input  logic [AW-1:0]     fillAdr,
    input  logic              memValid,
    input  logic [WIDTH-1:0]  memData,
    input  logic              memPar,
    input  logic              nxm,
    input  logic              ebLoad,
    input  logic [AW-1:0]     ebAdr,
    input  logic [WIDTH-1:0]  ebData,
    input  logic [AW-1:0]     rdAdr,
    output logic [WIDTH-1:0]  rdData,
    output logic              rdPar,
    output logic              rdValid,
    output logic [NWORDS-1:0] wordValid,
    output logic              busy,
    output logic              done,
    output logic              parErr,
    output logic [AW-1:0]     parErrAdr,
    output logic              nxmErr,
    output logic              ebReject,
    input  logic              clrErr,
    input  logic              chWr,
    input  logic [WIDTH-1:0]  chWrData,
    input  logic              chReverse,
    input  logic              chRd,
    output logic [WIDTH-1:0]  chRdData,
    output logic              chRdValid,
    output logic              chFull,
    output logic              chEmpty,
    output logic [CW:0]       chCount,
    output logic              chOvf
);

    // state   | meaning
    // IDLE    | line idle; EBOX stores accepted, fillStart starts a fill
    // FILL    | accepting memory words into ptr, busy asserted
    // DONE    | one-cycle done pulse, EBOX stores accepted

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] CNT_LAST = (AW+1)'(NWORDS - 1);
    localparam logic [CW:0] CH_FULL  = (CW+1)'(CHDEPTH);

    state_t             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]   mem_q [NWORDS];
    logic [WIDTH-1:0]   mem_d [NWORDS];
    logic [NWORDS-1:0]  valid_q, valid_d;
    logic               par_err_q, par_err_d;
    logic [AW-1:0]      par_err_adr_q, par_err_adr_d;
    logic               nxm_err_q, nxm_err_d;
    logic               eb_reject_q, eb_reject_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic               rd_par_q, rd_par_d;
    logic               rd_valid_q, rd_valid_d;
    logic               mem_par_ok;

    assign mem_par_ok = ^{memData, memPar};

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        mem_d         = mem_q;
        valid_d       = valid_q;
        par_err_d     = par_err_q;
        par_err_adr_d = par_err_adr_q;
        nxm_err_d     = nxm_err_q;
        eb_reject_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fillStart) begin
                    state_d     = ST_FILL;
                    valid_d     = '0;
                    ptr_d       = fillAdr;
                    cnt_d       = '0;
                    eb_reject_d = ebLoad;
                end else if (ebLoad) begin
                    mem_d[ebAdr]   = ebData;
                    valid_d[ebAdr] = 1'b1;
                end
            end
            ST_FILL: begin
                eb_reject_d = ebLoad;
                // An abort discards any word arriving in the same cycle.
                if (nxm) begin
                    state_d   = ST_IDLE;
                    nxm_err_d = 1'b1;
                end else if (memValid) begin
                    mem_d[ptr_q]   = memData;
                    valid_d[ptr_q] = 1'b1;
                    ptr_d          = ptr_q + 1'b1;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                    if (!mem_par_ok && !par_err_q) begin
                        par_err_d     = 1'b1;
                        par_err_adr_d = ptr_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (ebLoad) begin
                    mem_d[ebAdr]   = ebData;
                    valid_d[ebAdr] = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clrErr) begin
            par_err_d     = 1'b0;
            par_err_adr_d = '0;
            nxm_err_d     = 1'b0;
        end

        // Read-before-write: samples the slot as it stands before this edge.
        rd_data_d  = mem_q[rdAdr];
        rd_par_d   = ~^mem_q[rdAdr];
        rd_valid_d = valid_q[rdAdr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            mem_q         <= '{default: '0};
            valid_q       <= '0;
            par_err_q     <= 1'b0;
            par_err_adr_q <= '0;
            nxm_err_q     <= 1'b0;
            eb_reject_q   <= 1'b0;
            rd_data_q     <= '0;
            rd_par_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            mem_q         <= mem_d;
            valid_q       <= valid_d;
            par_err_q     <= par_err_d;
            par_err_adr_q <= par_err_adr_d;
            nxm_err_q     <= nxm_err_d;
            eb_reject_q   <= eb_reject_d;
            rd_data_q     <= rd_data_d;
            rd_par_q      <= rd_par_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign rdData    = rd_data_q;
    assign rdPar     = rd_par_q;
    assign rdValid   = rd_valid_q;
    assign wordValid = valid_q;
    assign busy      = (state_q == ST_FILL);
    assign done      = (state_q == ST_DONE);
    assign parErr    = par_err_q;
    assign parErrAdr = par_err_adr_q;
    assign nxmErr    = nxm_err_q;
    assign ebReject  = eb_reject_q;

    logic [WIDTH-1:0] fifo_q [CHDEPTH];
    logic [WIDTH-1:0] fifo_d [CHDEPTH];
    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW:0]      ch_count_q, ch_count_d;
    logic             ch_ovf_q, ch_ovf_d;
    logic [WIDTH-1:0] ch_rd_data_q, ch_rd_data_d;
    logic             ch_rd_valid_q, ch_rd_valid_d;
    logic             ch_full, ch_empty, ch_push, ch_pop;
    logic [WIDTH-1:0] ch_word;

    assign ch_full  = (ch_count_q == CH_FULL);
    assign ch_empty = (ch_count_q == '0);
    // A pop in the same cycle frees the slot a full-FIFO push lands in.
    assign ch_push  = chWr && (!ch_full || chRd);
    assign ch_pop   = chRd && !ch_empty;
    assign ch_word  = chReverse ? {chWrData[WIDTH/2-1:0], chWrData[WIDTH-1:WIDTH/2]}
                                : chWrData;

    always_comb begin
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ch_count_d    = ch_count_q;
        ch_rd_data_d  = ch_rd_data_q;
        ch_rd_valid_d = ch_pop;
        ch_ovf_d      = ch_ovf_q | (chWr && ch_full && !chRd);

        if (ch_push) begin
            fifo_d[wr_ptr_q] = ch_word;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (ch_pop) begin
            ch_rd_data_d = fifo_q[rd_ptr_q];
            rd_ptr_d     = rd_ptr_q + 1'b1;
        end
        case ({ch_push, ch_pop})
            2'b10:   ch_count_d = ch_count_q + 1'b1;
            2'b01:   ch_count_d = ch_count_q - 1'b1;
            default: ch_count_d = ch_count_q;
        endcase
        if (clrErr) begin
            ch_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q        <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ch_count_q    <= '0;
            ch_ovf_q      <= 1'b0;
            ch_rd_data_q  <= '0;
            ch_rd_valid_q <= 1'b0;
        end else begin
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ch_count_q    <= ch_count_d;
            ch_ovf_q      <= ch_ovf_d;
            ch_rd_data_q  <= ch_rd_data_d;
            ch_rd_valid_q <= ch_rd_valid_d;
        end
    end

    assign chRdData  = ch_rd_data_q;
    assign chRdValid = ch_rd_valid_q;
    assign chFull    = ch_full;
    assign chEmpty   = ch_empty;
    assign chCount   = ch_count_q;
    assign chOvf     = ch_ovf_q;

endmodule

// File: tb/tb_mb_wbuf.sv
// Scoreboard bench for mb_wbuf with NWORDS=4, CHDEPTH=4.
module tb_mb_wbuf;
    localparam int WIDTH   = 36;
    localparam int NWORDS  = 4;
    localparam int CHDEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fillStart, memValid, memPar, nxm, ebLoad, clrErr;
    logic [1:0]        fillAdr, ebAdr, rdAdr;
    logic [WIDTH-1:0]  memData, ebData, chWrData;
    logic [WIDTH-1:0]  rdData, chRdData;
    logic              rdPar, rdValid, busy, done, parErr, nxmErr, ebReject;
    logic [1:0]        parErrAdr;
    logic [3:0]        wordValid;
    logic              chWr, chReverse, chRd, chRdValid, chFull, chEmpty, chOvf;
    logic [2:0]        chCount;

    mb_wbuf #(.WIDTH(WIDTH), .NWORDS(NWORDS), .CHDEPTH(CHDEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .fillStart(fillStart), .fillAdr(fillAdr),
        .memValid(memValid), .memData(memData), .memPar(memPar), .nxm(nxm),
        .ebLoad(ebLoad), .ebAdr(ebAdr), .ebData(ebData),
        .rdAdr(rdAdr), .rdData(rdData), .rdPar(rdPar), .rdValid(rdValid),
        .wordValid(wordValid), .busy(busy), .done(done),
        .parErr(parErr), .parErrAdr(parErrAdr), .nxmErr(nxmErr),
        .ebReject(ebReject), .clrErr(clrErr),
        .chWr(chWr), .chWrData(chWrData), .chReverse(chReverse), .chRd(chRd),
        .chRdData(chRdData), .chRdValid(chRdValid),
        .chFull(chFull), .chEmpty(chEmpty), .chCount(chCount), .chOvf(chOvf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             par;
        logic             valid;
    } rd_exp_t;

    int               n_checks = 0;
    int               n_pass   = 0;
    logic [WIDTH-1:0] exp_mem [NWORDS];
    logic [3:0]       exp_valid;
    logic             exp_par_err, exp_nxm, exp_ovf;
    logic [1:0]       exp_par_adr;
    logic [WIDTH-1:0] ch_q [$];
    rd_exp_t          rd_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        return {4'($urandom), 32'($urandom)};
    endfunction

    task automatic check_flags(input string tag);
        check({tag, "_parErr"}, parErr, exp_par_err);
        check({tag, "_parErrAdr"}, parErrAdr, exp_par_adr);
        check({tag, "_nxmErr"}, nxmErr, exp_nxm);
        check({tag, "_chOvf"}, chOvf, exp_ovf);
    endtask

    task automatic clear_errs();
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        exp_par_err = 1'b0;
        exp_par_adr = '0;
        exp_nxm     = 1'b0;
        exp_ovf     = 1'b0;
        check_flags("clr");
    endtask

    task automatic read_slot(input logic [1:0] adr);
        rd_exp_t e;
        rdAdr = adr;
        e.data  = exp_mem[adr];
        e.par   = ~^exp_mem[adr];
        e.valid = exp_valid[adr];
        rd_q.push_back(e);
        tick();
        e = rd_q.pop_front();
        check("rd_data", rdData, e.data);
        check("rd_par", rdPar, e.par);
        check("rd_valid", rdValid, e.valid);
    endtask

    task automatic run_fill(input logic [1:0] adr, input int n, input logic [3:0] bad,
                            input bit abort, input bit gap);
        logic [1:0]       slot;
        logic [WIDTH-1:0] w;
        fillStart = 1'b1;
        fillAdr   = adr;
        tick();
        fillStart = 1'b0;
        exp_valid = '0;
        check("fill_busy", busy, 1'b1);
        check("fill_clr_valid", wordValid, exp_valid);
        for (int i = 0; i < n; i++) begin
            slot     = adr + 2'(i);
            w        = rnd_word();
            memValid = 1'b1;
            memData  = w;
            memPar   = bad[i] ? ^w : ~^w;
            exp_mem[slot]   = w;
            exp_valid[slot] = 1'b1;
            if (bad[i] && !exp_par_err) begin
                exp_par_err = 1'b1;
                exp_par_adr = slot;
            end
            tick();
            memValid = 1'b0;
            if (!abort && i == n - 1) begin
                check("fill_done", done, 1'b1);
                check("fill_busy_done", busy, 1'b0);
            end else begin
                check("fill_no_done", done, 1'b0);
                check("fill_busy_mid", busy, 1'b1);
            end
            if (gap && i == 1) begin
                tick();
                check("fill_gap_busy", busy, 1'b1);
            end
        end
        if (abort) begin
            nxm      = 1'b1;
            memValid = 1'b1;
            memData  = rnd_word();
            memPar   = ~^memData;
            tick();
            nxm      = 1'b0;
            memValid = 1'b0;
            exp_nxm  = 1'b1;
            check("nxm_busy", busy, 1'b0);
            check("nxm_done", done, 1'b0);
        end
        tick();
        check("fill_done_end", done, 1'b0);
        check("fill_valid", wordValid, exp_valid);
        check_flags("fill");
    endtask

    task automatic ch_op(input bit wr, input bit rev, input logic [WIDTH-1:0] d, input bit rd);
        int               sz;
        bit               do_pop;
        logic [WIDTH-1:0] popped;
        logic [WIDTH-1:0] w;
        sz     = ch_q.size();
        do_pop = rd && (sz > 0);
        popped = '0;
        w      = rev ? {d[17:0], d[35:18]} : d;
        chWr = wr; chReverse = rev; chWrData = d; chRd = rd;
        if (do_pop) popped = ch_q.pop_front();
        if (wr && (sz < CHDEPTH || rd)) ch_q.push_back(w);
        if (wr && sz == CHDEPTH && !rd) exp_ovf = 1'b1;
        tick();
        chWr = 1'b0; chRd = 1'b0; chReverse = 1'b0;
        check("ch_rd_valid", chRdValid, do_pop);
        if (do_pop) check("ch_rd_data", chRdData, popped);
        check("ch_count", chCount, ch_q.size());
        check("ch_full", chFull, ch_q.size() == CHDEPTH);
        check("ch_empty", chEmpty, ch_q.size() == 0);
        check("ch_ovf", chOvf, exp_ovf);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NWORDS; i++) exp_mem[i] = '0;
        exp_valid   = '0;
        exp_par_err = 1'b0;
        exp_par_adr = '0;
        exp_nxm     = 1'b0;
        exp_ovf     = 1'b0;
        ch_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdData"}, rdData, '0);
        check({tag, "_rdPar"}, rdPar, 1'b0);
        check({tag, "_rdValid"}, rdValid, 1'b0);
        check({tag, "_wordValid"}, wordValid, 4'b0000);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_ebReject"}, ebReject, 1'b0);
        check({tag, "_chRdData"}, chRdData, '0);
        check({tag, "_chRdValid"}, chRdValid, 1'b0);
        check({tag, "_chCount"}, chCount, 3'd0);
        check({tag, "_chFull"}, chFull, 1'b0);
        check({tag, "_chEmpty"}, chEmpty, 1'b1);
        check_flags(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] eb_word;
        fillStart = 0; fillAdr = 0; memValid = 0; memData = 0; memPar = 0; nxm = 0;
        ebLoad = 0; ebAdr = 0; ebData = 0; rdAdr = 0; clrErr = 0;
        chWr = 0; chWrData = 0; chReverse = 0; chRd = 0;
        model_reset();

        repeat (2) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        run_fill(2'd2, 4, 4'b0000, 1'b0, 1'b0);
        check("wrap_valid_all", wordValid, 4'b1111);
        for (int i = 0; i < NWORDS; i++) read_slot(2'(i));

        run_fill(2'd2, 4, 4'b0010, 1'b0, 1'b1);
        check("par_adr_first", parErrAdr, 2'd3);
        run_fill(2'd0, 4, 4'b1000, 1'b0, 1'b0);
        check("par_adr_sticky", parErrAdr, 2'd3);
        clear_errs();

        run_fill(2'd0, 2, 4'b0000, 1'b1, 1'b0);
        check("nxm_partial_valid", wordValid, 4'b0011);
        for (int i = 0; i < NWORDS; i++) read_slot(2'(i));
        clear_errs();

        eb_word = 36'o123456765432;
        ebLoad = 1'b1; ebAdr = 2'd1; ebData = eb_word;
        exp_mem[1] = eb_word; exp_valid[1] = 1'b1;
        tick();
        ebLoad = 1'b0;
        check("eb_accept_noreject", ebReject, 1'b0);
        check("eb_valid", wordValid, exp_valid);
        read_slot(2'd1);

        fillStart = 1'b1; fillAdr = 2'd0;
        ebLoad = 1'b1; ebAdr = 2'd3; ebData = 36'o111111111111;
        tick();
        fillStart = 1'b0;
        exp_valid = '0;
        check("eb_rej_with_start", ebReject, 1'b1);
        check("eb_rej_busy", busy, 1'b1);
        tick();
        check("eb_rej_in_fill", ebReject, 1'b1);
        ebLoad = 1'b0;
        nxm = 1'b1;
        tick();
        nxm = 1'b0;
        exp_nxm = 1'b1;
        check("eb_rej_clear", ebReject, 1'b0);
        check_flags("eb_abort");
        read_slot(2'd3);
        clear_errs();

        ch_op(1'b1, 1'b1, 36'o000001777777, 1'b0);
        for (int i = 0; i < 3; i++) ch_op(1'b1, 1'b0, rnd_word(), 1'b0);
        ch_op(1'b1, 1'b0, rnd_word(), 1'b0);
        ch_op(1'b1, 1'b0, rnd_word(), 1'b1);
        check("ch_first_pop_swap", chRdData, 36'o777777000001);
        for (int i = 0; i < 4; i++) ch_op(1'b0, 1'b0, '0, 1'b1);
        ch_op(1'b0, 1'b0, '0, 1'b1);
        ch_op(1'b1, 1'b1, rnd_word(), 1'b1);
        ch_op(1'b0, 1'b0, '0, 1'b1);
        clear_errs();

        for (int i = 0; i < 3; i++) ch_op(1'b1, 1'b0, rnd_word(), 1'b0);
        fillStart = 1'b1; fillAdr = 2'd1;
        tick();
        fillStart = 1'b0;
        memValid = 1'b1; memData = rnd_word(); memPar = ~^memData;
        tick();
        memValid = 1'b0;
        check("pre_rst_count", chCount, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        run_fill(2'd1, 4, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < NWORDS; i++) read_slot(2'(i));
        ch_op(1'b0, 1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
